section_pipe: RTL and testbench
===============================

Name: section_pipe

Overview:
- One trellis section of the fully parallel turbo decoder (FPTD). It covers an 8-state LTE RSC constituent code using the max-log-MAP update.
- Each cycle it takes the a priori and channel LLRs for one bit, plus the neighbouring sections' forward (alpha) and backward (beta) state metrics.
- It produces registered updated alpha, beta and the extrinsic LLR be1.
- Many instances are chained side by side. alpha_out feeds the next section's alpha_in; beta_out feeds the previous section's beta_in.

Parameters:
- N, 6, width of the channel LLRs ba2 and ba3 (signed two's complement).
- M, 6, width of ba1, the state metrics and be1 (signed two's complement).

Ports:
- Clock, input, 1, system clock; all state updates on the rising edge.
- nReset, input, 1, reset; synchronous, active-high. The name is historical; the reset is asserted when the signal is 1.
- nClear, input, 1, synchronous clear, active-low.
- Enable, input, 1, register load enable.
- ba1, input, M, a priori LLR of the systematic bit b1.
- ba2, input, N, channel LLR of the systematic bit.
- ba3, input, N, channel LLR of the parity bit b2.
- alpha_in, input, 7xM packed [7:1], forward metrics of states 1..7 at this section's left edge. State 0 is implicitly 0.
- beta_in, input, 7xM packed [7:1], backward metrics of states 1..7 at the right edge. State 0 is implicitly 0.
- alpha_out, output, 7xM packed [7:1], normalised forward metrics of states 1..7 at the right edge.
- beta_out, output, 7xM packed [7:1], normalised backward metrics of states 1..7 at the left edge.
- be1, output, M, extrinsic LLR of b1.

Behaviour:
- State encoding: S = {s1,s2,s3}, with s1 as the MSB.
  - Feedback bit: a = b1^s2^s3.
  - Parity bit: b2 = a^s1^s3.
  - Next state: {a,s1,s2}.
- Transition table, one line per from-state, giving "b1=0 (to-state, b2); b1=1 (to-state, b2)":
  - S0: b1=0 (0,0); b1=1 (4,1)
  - S1: b1=0 (4,0); b1=1 (0,1)
  - S2: b1=0 (5,1); b1=1 (1,0)
  - S3: b1=0 (1,1); b1=1 (5,0)
  - S4: b1=0 (2,1); b1=1 (6,0)
  - S5: b1=0 (6,1); b1=1 (2,0)
  - S6: b1=0 (7,0); b1=1 (3,1)
  - S7: b1=0 (3,0); b1=1 (7,1)
- Branch metric: gamma = b1*(ba1+ba2) + b2*ba3.
- Forward update: A(s) = max over transitions S'->s of (alpha(S') + gamma).
- Backward update: B(S') = max over transitions S'->s of (beta(s) + gamma).
- Extrinsic: be1 = max over b1=1 transitions of (alpha(S') + b2*ba3 + beta(s)) minus the same maximum over b1=0 transitions. ba1 and ba2 are excluded.
- Normalisation: alpha_out[k] = A(k) - A(0) and beta_out[k] = B(k) - B(0), for k = 1..7.
- Arithmetic rules:
  - All inputs are sign-extended to M+4 bits.
  - Intermediates use full precision, so there is no internal overflow.
  - Every output is saturated to [-2^(M-1), 2^(M-1)-1], which is [-32, 31] at the defaults.
- Pipeline and latency:
  - The datapath is combinational into a single output register stage.
  - Latency is 1 clock: outputs reflect the inputs sampled at the previous rising edge.
- Control priority, evaluated at each rising edge:
  1. nReset=1: all outputs become 0.
  2. Otherwise, nClear=0: all outputs become 0, regardless of Enable.
  3. Otherwise, Enable=1: load the computed values.
  4. Otherwise: hold.
- Reset mid-operation takes effect at the next edge and overrides everything. Values before the first reset are don't-care.

Test Plan:
- Reset: nReset=1 for one edge with arbitrary inputs -> alpha_out, beta_out and be1 are all 0. Deassert with all inputs 0 and Enable=1 -> outputs stay 0.
- Asymmetric metrics: alpha_in[1]=10, beta_in[4]=6, all others 0, ba1=ba2=ba3=0, Enable=1, nClear=1 -> after 1 clock:
  - alpha_out[4]=0 and alpha_out[1,2,3,5,6,7]=-10;
  - beta_out[1]=0 and beta_out[2..7]=-6;
  - be1=-6.
- Saturation: alpha_in[1]=-32, other alpha 0, beta 0, ba1=31, ba2=31, ba3=0 -> alpha_out[1..7] all 31 (the raw value 32 clips); be1=0.
- Parity only: ba3=5, ba1=ba2=0, all metrics 0 -> alpha_out=0, beta_out=0, be1=0.
- Control:
  - Load the asymmetric-metrics vector, then set Enable=0, nClear=1 and change the inputs -> outputs hold.
  - Set nClear=0 with Enable=1 -> outputs are 0 at the next edge.
  - Set nClear=0 with Enable=0 -> outputs remain 0.

Source files
------------

// File: rtl/section_pipe.sv
// section_pipe -- one trellis section of a fully parallel turbo decoder.
//
// Implements the max-log-MAP update for a single bit of the 8-state LTE RSC
// constituent code. All section logic is combinational into one output
// register stage, so the latency is one clock.
//
// Ports
//   Clock      : rising-edge clock
//   nReset     : synchronous reset, asserted HIGH (the name is historical)
//   nClear     : synchronous clear, active low; wins over Enable
//   Enable     : output register load enable
//   ba1        : a priori LLR of systematic bit b1            (M bits, signed)
//   ba2, ba3   : channel LLRs of systematic / parity bit      (N bits, signed)
//   alpha_in   : forward metrics, states 1..7, left edge      (state 0 == 0)
//   beta_in    : backward metrics, states 1..7, right edge    (state 0 == 0)
//   alpha_out  : normalised forward metrics, right edge
//   beta_out   : normalised backward metrics, left edge
//   be1        : extrinsic LLR of b1
module section_pipe #(
  parameter int N = 6,
  parameter int M = 6
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 nClear,
  input  logic                 Enable,
  input  logic [M-1:0]         ba1,
  input  logic [N-1:0]         ba2,
  input  logic [N-1:0]         ba3,
  input  logic [7:1][M-1:0]    alpha_in,
  input  logic [7:1][M-1:0]    beta_in,
  output logic [7:1][M-1:0]    alpha_out,
  output logic [7:1][M-1:0]    beta_out,
  output logic [M-1:0]         be1
);

  // Internal width: four guard bits cover the sum of a metric, two LLR terms
  // and a second metric, plus the normalising subtraction.
  localparam int W = M + 4;
  localparam logic signed [W-1:0] SMAX = W'((2 ** (M - 1)) - 1);
  localparam logic signed [W-1:0] SMIN = -SMAX - W'(1);
  // Starting point for the running maxima; no real candidate gets this low.
  localparam logic signed [W-1:0] NEG  = {1'b1, {(W-1){1'b0}}};

  // Encoder: S = {s1,s2,s3}; a = b1^s2^s3; next = {a,s1,s2}.
  function automatic logic [2:0] f_next(input logic [2:0] s, input logic b);
    logic a;
    a = b ^ s[1] ^ s[0];
    return {a, s[2], s[1]};
  endfunction

  // Parity output b2 = a^s1^s3.
  function automatic logic f_par(input logic [2:0] s, input logic b);
    return (b ^ s[1] ^ s[0]) ^ s[2] ^ s[0];
  endfunction

  function automatic logic [M-1:0] f_sat(input logic signed [W-1:0] x);
    if (x > SMAX)      return SMAX[M-1:0];
    else if (x < SMIN) return SMIN[M-1:0];
    else               return x[M-1:0];
  endfunction

  logic signed [W-1:0] w_ba12, w_ba3;
  logic signed [W-1:0] w_alpha [8];
  logic signed [W-1:0] w_beta  [8];
  logic signed [W-1:0] w_A     [8];
  logic signed [W-1:0] w_B     [8];
  logic signed [W-1:0] w_e0, w_e1;
  logic [7:1][M-1:0]   w_alpha_n, w_beta_n;
  logic [M-1:0]        w_be1;

  always_comb begin
    logic [2:0]          s, ns;
    logic                bb, p;
    logic signed [W-1:0] g_par, g, ca, cb, ce;
    s     = '0;
    ns    = '0;
    bb    = 1'b0;
    p     = 1'b0;
    g_par = '0;
    g     = '0;
    ca    = '0;
    cb    = '0;
    ce    = '0;
    w_ba12 = {{(W-M){ba1[M-1]}}, ba1} + {{(W-N){ba2[N-1]}}, ba2};
    w_ba3  = {{(W-N){ba3[N-1]}}, ba3};
    w_alpha[0] = '0;
    w_beta[0]  = '0;
    for (int k = 1; k < 8; k++) begin
      w_alpha[k] = {{(W-M){alpha_in[k][M-1]}}, alpha_in[k]};
      w_beta[k]  = {{(W-M){beta_in[k][M-1]}},  beta_in[k]};
    end
    for (int k = 0; k < 8; k++) begin
      w_A[k] = NEG;
      w_B[k] = NEG;
    end
    w_e0 = NEG;
    w_e1 = NEG;
    // Walk all 16 branches once; each contributes to the forward max of its
    // to-state, the backward max of its from-state and one extrinsic max.
    for (int sp = 0; sp < 8; sp++) begin
      for (int b = 0; b < 2; b++) begin
        s     = 3'(sp);
        bb    = b[0];
        ns    = f_next(s, bb);
        p     = f_par(s, bb);
        g_par = p  ? w_ba3  : '0;
        g     = (bb ? w_ba12 : '0) + g_par;
        ca    = w_alpha[s] + g;
        cb    = w_beta[ns] + g;
        // Extrinsic drops the systematic terms (ba1+ba2).
        ce    = w_alpha[s] + g_par + w_beta[ns];
        if (ca > w_A[ns]) w_A[ns] = ca;
        if (cb > w_B[s])  w_B[s]  = cb;
        if (bb) begin
          if (ce > w_e1) w_e1 = ce;
        end else begin
          if (ce > w_e0) w_e0 = ce;
        end
      end
    end
    for (int k = 1; k < 8; k++) begin
      w_alpha_n[k] = f_sat(w_A[k] - w_A[0]);
      w_beta_n[k]  = f_sat(w_B[k] - w_B[0]);
    end
    w_be1 = f_sat(w_e1 - w_e0);
  end

  logic [7:1][M-1:0] r_alpha, r_beta;
  logic [M-1:0]      r_be1;

  always_ff @(posedge Clock) begin
    if (nReset || !nClear) begin
      r_alpha <= '0;
      r_beta  <= '0;
      r_be1   <= '0;
    end else if (Enable) begin
      r_alpha <= w_alpha_n;
      r_beta  <= w_beta_n;
      r_be1   <= w_be1;
    end
  end

  assign alpha_out = r_alpha;
  assign beta_out  = r_beta;
  assign be1       = r_be1;

endmodule

// File: tb/tb_section_pipe.sv
module tb_section_pipe;
  localparam int N = 6;
  localparam int M = 6;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic              nReset, nClear, Enable;
  logic [M-1:0]      ba1;
  logic [N-1:0]      ba2, ba3;
  logic [7:1][M-1:0] alpha_in, beta_in, alpha_out, beta_out;
  logic [M-1:0]      be1;

  section_pipe #(.N(N), .M(M)) dut (
    .Clock(Clock), .nReset(nReset), .nClear(nClear), .Enable(Enable),
    .ba1(ba1), .ba2(ba2), .ba3(ba3),
    .alpha_in(alpha_in), .beta_in(beta_in),
    .alpha_out(alpha_out), .beta_out(beta_out), .be1(be1)
  );

  typedef struct {
    logic [7:1][5:0] a;
    logic [7:1][5:0] b;
    logic [5:0]      e;
  } exp_t;

  typedef struct {
    logic            rst, clr_n, en;
    logic [5:0]      b1, b2, b3;
    logic [7:1][5:0] ain, bin;
    exp_t            x;
  } vec_t;

  // Trellis straight from the transition table: [from][b1] -> to / parity.
  int NS [8][2] = '{'{0,4}, '{4,0}, '{5,1}, '{1,5}, '{2,6}, '{6,2}, '{7,3}, '{3,7}};
  int PB [8][2] = '{'{0,1}, '{0,1}, '{1,0}, '{1,0}, '{1,0}, '{1,0}, '{0,1}, '{0,1}};

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic logic [5:0] sat6(int v);
    if (v > 31)  v = 31;
    if (v < -32) v = -32;
    return 6'(v);
  endfunction

  function automatic logic [7:1][5:0] pk(int dflt, int k, int v);
    logic [7:1][5:0] r;
    for (int i = 1; i < 8; i++) r[i] = (i == k) ? 6'(v) : 6'(dflt);
    return r;
  endfunction

  function automatic exp_t model(logic [5:0] b1, logic [5:0] b2, logic [5:0] b3,
                                 logic [7:1][5:0] ain, logic [7:1][5:0] bin);
    int al[8], bt[8], A[8], B[8];
    int e0, e1, g, gp, i1, i2, i3, t;
    exp_t x;
    i1 = $signed(b1); i2 = $signed(b2); i3 = $signed(b3);
    al[0] = 0; bt[0] = 0;
    for (int k = 1; k < 8; k++) begin
      al[k] = $signed(ain[k]);
      bt[k] = $signed(bin[k]);
    end
    for (int k = 0; k < 8; k++) begin A[k] = -100000; B[k] = -100000; end
    e0 = -100000; e1 = -100000;
    for (int s = 0; s < 8; s++) begin
      for (int b = 0; b < 2; b++) begin
        t  = NS[s][b];
        gp = PB[s][b] * i3;
        g  = b * (i1 + i2) + gp;
        if (al[s] + g > A[t]) A[t] = al[s] + g;
        if (bt[t] + g > B[s]) B[s] = bt[t] + g;
        if (b == 1) begin
          if (al[s] + gp + bt[t] > e1) e1 = al[s] + gp + bt[t];
        end else begin
          if (al[s] + gp + bt[t] > e0) e0 = al[s] + gp + bt[t];
        end
      end
    end
    for (int k = 1; k < 8; k++) begin
      x.a[k] = sat6(A[k] - A[0]);
      x.b[k] = sat6(B[k] - B[0]);
    end
    x.e = sat6(e1 - e0);
    return x;
  endfunction

  function automatic vec_t mkv(logic rst, logic clr_n, logic en, int b1, int b2, int b3,
                               logic [7:1][5:0] ain, logic [7:1][5:0] bin,
                               logic [7:1][5:0] xa, logic [7:1][5:0] xb, int xe);
    vec_t v;
    v.rst = rst; v.clr_n = clr_n; v.en = en;
    v.b1 = 6'(b1); v.b2 = 6'(b2); v.b3 = 6'(b3);
    v.ain = ain; v.bin = bin;
    v.x.a = xa; v.x.b = xb; v.x.e = 6'(xe);
    return v;
  endfunction

  task automatic check(string nm, int idx, logic [41:0] act, logic [41:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  // Drive one vector, log its expectation, then compare after the edge.
  task automatic apply(input vec_t v, input int idx);
    exp_t x;
    @(negedge Clock);
    nReset = v.rst; nClear = v.clr_n; Enable = v.en;
    ba1 = v.b1; ba2 = v.b2; ba3 = v.b3;
    alpha_in = v.ain; beta_in = v.bin;
    q.push_back(v.x);
    @(posedge Clock);
    #1;
    if (q.size() == 0) begin
      n_chk++;
      $display("FAIL scoreboard[%0d]: queue empty", idx);
    end else begin
      x = q.pop_front();
      check("alpha_out", idx, 42'(alpha_out), 42'(x.a));
      check("beta_out",  idx, 42'(beta_out),  42'(x.b));
      check("be1",       idx, 42'(be1),       42'(x.e));
    end
  endtask

  vec_t vt[12];
  vec_t v;
  exp_t cur, z, asym, mx;

  initial begin
    logic [7:1][5:0] Z0, ASA, ASB, EA, EB;
    Z0  = pk(0, 0, 0);
    ASA = pk(0, 1, 10);
    ASB = pk(0, 4, 6);
    EA  = pk(-10, 4, 0);
    EB  = pk(-6, 1, 0);
    z.a = Z0; z.b = Z0; z.e = '0;
    asym.a = EA; asym.b = EB; asym.e = 6'(-6);

    nReset = 1'b1; nClear = 1'b1; Enable = 1'b0;
    ba1 = '0; ba2 = '0; ba3 = '0; alpha_in = '0; beta_in = '0;

    vt[0]  = mkv(1, 1, 1, 7, -3, 12, pk(3, 2, -5), pk(-8, 6, 20), Z0, Z0, 0);   // reset
    vt[1]  = mkv(0, 1, 1, 0, 0, 0, Z0, Z0, Z0, Z0, 0);                           // zero in
    vt[2]  = mkv(0, 1, 1, 0, 0, 0, ASA, ASB, EA, EB, -6);                        // asymmetric
    vt[3]  = mkv(0, 1, 1, 31, 31, 0, pk(0, 1, -32), Z0, pk(31, 0, 0), Z0, 0);    // saturation
    vt[4]  = mkv(0, 1, 1, 0, 0, 5, Z0, Z0, Z0, Z0, 0);                           // parity only
    vt[5]  = mkv(0, 1, 1, 0, 0, 0, ASA, ASB, EA, EB, -6);                        // reload
    vt[6]  = mkv(0, 1, 0, 9, -4, 9, pk(5, 3, 1), pk(-2, 7, 4), EA, EB, -6);      // hold
    vt[7]  = mkv(0, 0, 1, 0, 0, 0, ASA, ASB, Z0, Z0, 0);                         // clear, en=1
    vt[8]  = mkv(0, 0, 0, 0, 0, 0, ASA, ASB, Z0, Z0, 0);                         // clear, en=0
    vt[9]  = mkv(0, 1, 1, 0, 0, 0, ASA, ASB, EA, EB, -6);                        // reload
    vt[10] = mkv(1, 1, 1, 0, 0, 0, ASA, ASB, Z0, Z0, 0);                         // reset beats load
    vt[11] = mkv(0, 1, 0, 0, 0, 0, ASA, ASB, Z0, Z0, 0);                         // hold zero

    for (int i = 0; i < 12; i++) apply(vt[i], i);

    // Multi-cycle: load, hold for three edges under changing inputs, then
    // clear with Enable low from a non-zero state.
    apply(mkv(0, 1, 1, 0, 0, 0, ASA, ASB, EA, EB, -6), 100);
    for (int i = 0; i < 3; i++)
      apply(mkv(0, 1, 0, i * 3, -i, 7 - i, pk(i, 2, -i), pk(-i, 5, i), EA, EB, -6), 101 + i);
    apply(mkv(0, 0, 0, 4, 4, 4, ASA, ASB, Z0, Z0, 0), 104);

    // Random traffic against the reference model, with occasional hold,
    // clear and reset so the control priority is exercised under load.
    cur = z;
    for (int i = 0; i < 60; i++) begin
      v.b1 = 6'($urandom); v.b2 = 6'($urandom); v.b3 = 6'($urandom);
      for (int k = 1; k < 8; k++) begin
        v.ain[k] = 6'($urandom);
        v.bin[k] = 6'($urandom);
      end
      v.rst   = ($urandom_range(0, 15) == 0);
      v.clr_n = ($urandom_range(0, 7) != 0);
      v.en    = ($urandom_range(0, 3) != 0);
      mx = model(v.b1, v.b2, v.b3, v.ain, v.bin);
      if (v.rst || !v.clr_n) cur = z;
      else if (v.en)         cur = mx;
      v.x = cur;
      apply(v, 200 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
